gelato_simt_split_table: RTL and testbench
==========================================

Name: gelato_simt_split_table

Overview:
Parametrised per-warp SIMT split table with issue handshake.
- Tracks up to ENTRY_NUM thread groups of one warp. Each group has its own PC and thread mask.
- Splits a group on divergent branches and re-merges groups whose PCs meet again.
- Round-robin issues one ready group per cycle to the fetch stage.
- Sits between warp init / scheduler and fetch; the execute-side branch unit drives updates.

Parameters:
THREAD_NUM, 32, threads per warp (mask width)
ENTRY_NUM, 8, split table depth; must be a power of two, >= 2
PC_WIDTH, 32, program counter width
EW, $clog2(ENTRY_NUM), entry index width (derived, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global enable; when low, all state and outputs hold
init_valid  in  1  (re)start warp: clear table, entry 0 = init_pc with all threads
init_pc  in  PC_WIDTH  warp start PC
sel_valid  out  1  a group is offered to fetch
sel_ready  in  1  fetch accepts the offered group
sel_entry  out  EW  offered entry index
sel_pc  out  PC_WIDTH  offered PC
sel_mask  out  THREAD_NUM  offered thread mask
upd_valid  in  1  writeback for an in-flight entry
upd_ready  out  1  update accepted this cycle (combinational)
upd_entry  in  EW  entry being updated
upd_pc  in  PC_WIDTH  next PC for threads staying in the entry
upd_stall  in  1  entry parks until woken
upd_split  in  1  divergent branch
upd_split_pc  in  PC_WIDTH  PC for diverging threads
upd_split_mask  in  THREAD_NUM  threads that move to upd_split_pc
upd_exit  in  1  entry finished; free it
wake_valid  in  1  release a parked entry
wake_entry  in  EW  entry to release
full  out  1  no free entry
all_done  out  1  warp was initialised and now has no valid entries
overflow  out  1  sticky: a split was refused at least once since init

Behaviour:
- Entry state: valid, ready, inflight, parked, pc, mask.
- Reset: all entries invalid. All outputs 0, including sel_*, all_done and overflow.
- init_valid: highest priority when rdy=1.
  - Clears every entry, sel_valid, overflow and all_done.
  - Next cycle, entry 0 holds {valid, ready, pc=init_pc, mask=all ones}.
  - Updates and wakes in the same cycle are ignored.
- Select:
  - sel_* are registered, one-cycle latency from an entry becoming ready.
  - Scan order is last_issued+1 round-robin with modulo-ENTRY_NUM wrap. Pick the first entry that is valid, ready, not inflight, not parked and not merged away this cycle.
  - The offer holds stable while sel_valid && !sel_ready.
  - On sel_valid && sel_ready, the entry is marked inflight and last_issued is updated. A new offer may appear the next cycle, but never the same entry again until it is updated.
- Update: upd_ready = rdy && !init_valid && !(nontrivial split && full).
  - Accepted only with upd_valid && upd_ready. upd_entry must be inflight; otherwise the update is ignored.
  - Clears inflight.
  - upd_exit: invalidates the entry; other fields are ignored.
  - Without a split: pc <= upd_pc, parked <= upd_stall.
  - split_mask' = upd_split_mask & mask.
    - split_mask' == 0: treated as no split.
    - split_mask' == mask: pc <= upd_split_pc, no allocation.
    - Otherwise (nontrivial): original entry keeps mask & ~split_mask' at upd_pc. The lowest free index gets split_mask' at upd_split_pc. Both inherit upd_stall.
  - Nontrivial split while full: upd_ready=0, table unchanged, overflow set sticky. The branch unit retries.
- Wake: wake_valid clears parked on a valid entry. If the same cycle also has an accepted update to that entry, the update's upd_stall wins.
- Merge:
  - At most one merge per cycle.
  - Candidates are the lowest-index pair i<j where both entries are valid, not inflight, not parked, have equal pc, and neither is the upd_entry or wake_entry this cycle.
  - Entry i mask <= mask_i | mask_j; entry j invalidated.
  - Entry j is excluded from select that cycle.
- full = all entries valid. all_done registered.
- rdy=0: no state change, sel_* hold, upd_ready=0.
- Asynchronous reset mid-operation discards all groups immediately.

Test Plan:
- Reset, then init_valid with init_pc=0x100 -> cycle+2 sel_valid=1, sel_entry=0, sel_pc=0x100, sel_mask=0xFFFFFFFF. Entry is not re-offered before an update.
- Issue entry 0. Update upd_pc=0x104, upd_split=1, upd_split_pc=0x200, mask=0x0000FFFF -> entry 0 is {0x104, 0xFFFF0000} and entry 1 is {0x200, 0x0000FFFF}. Offers alternate 0, 1, 0.
- Entries 0 and 1 updated to pc 0x300 -> merge into entry 0 with mask 0xFFFFFFFF. Entry 1 freed; full=0.
- Fill all 8 entries, then request a nontrivial split -> upd_ready=0, table unchanged, overflow=1. Exiting one entry lets the retry succeed.
- Update with upd_stall=1 -> entry never offered. Same-cycle wake plus update with stall=0 -> not parked, offered next. Wake alone -> offered.
- Exit every entry -> all_done=1, sel_valid=0. sel_ready held low keeps the offer stable; rdy=0 freezes everything for 5 cycles.

Source files
------------

// File: rtl/gelato_simt_split_table_if.sv
// Fetch-issue, branch-writeback and wake signals of the SIMT split table.
// The table itself is the slave; fetch and the branch unit together are the master.
interface gelato_simt_split_table_if #(
   parameter int THREAD_NUM = 32,
   parameter int ENTRY_NUM  = 8,
   parameter int PC_WIDTH   = 32
);
   localparam int EW = $clog2(ENTRY_NUM);

   logic                  sel_valid;
   logic                  sel_ready;
   logic [EW-1:0]         sel_entry;
   logic [PC_WIDTH-1:0]   sel_pc;
   logic [THREAD_NUM-1:0] sel_mask;

   logic                  upd_valid;
   logic                  upd_ready;
   logic [EW-1:0]         upd_entry;
   logic [PC_WIDTH-1:0]   upd_pc;
   logic                  upd_stall;
   logic                  upd_split;
   logic [PC_WIDTH-1:0]   upd_split_pc;
   logic [THREAD_NUM-1:0] upd_split_mask;
   logic                  upd_exit;

   logic                  wake_valid;
   logic [EW-1:0]         wake_entry;

   modport slave (
      output sel_valid, sel_entry, sel_pc, sel_mask, upd_ready,
      input  sel_ready, upd_valid, upd_entry, upd_pc, upd_stall, upd_split,
             upd_split_pc, upd_split_mask, upd_exit, wake_valid, wake_entry
   );

   modport master (
      input  sel_valid, sel_entry, sel_pc, sel_mask, upd_ready,
      output sel_ready, upd_valid, upd_entry, upd_pc, upd_stall, upd_split,
             upd_split_pc, upd_split_mask, upd_exit, wake_valid, wake_entry
   );
endinterface

// File: rtl/gelato_simt_split_table.sv
// Per-warp SIMT split table: splits groups on divergent branches, re-merges
// groups that reach the same PC, and round-robin issues ready groups to fetch.
module gelato_simt_split_table #(
   parameter  int THREAD_NUM = 32,
   parameter  int ENTRY_NUM  = 8,
   parameter  int PC_WIDTH   = 32,
   localparam int EW         = $clog2(ENTRY_NUM)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rdy,
   input  logic                init_valid,
   input  logic [PC_WIDTH-1:0] init_pc,
   gelato_simt_split_table_if.slave bus,
   output logic                full,
   output logic                all_done,
   output logic                overflow
);

   typedef logic [PC_WIDTH-1:0]   pc_t;
   typedef logic [THREAD_NUM-1:0] mask_t;
   typedef logic [EW-1:0]         idx_t;

   logic [ENTRY_NUM-1:0] valid_q;
   logic [ENTRY_NUM-1:0] inflight_q;
   logic [ENTRY_NUM-1:0] parked_q;
   pc_t                  pc_q   [ENTRY_NUM];
   mask_t                mask_q [ENTRY_NUM];
   idx_t                 last_q;
   logic                 started_q;

   logic  run;
   logic  sel_fire;
   mask_t upd_cur_mask;
   mask_t split_eff;
   logic  split_any;
   logic  split_all;
   logic  split_nt;
   logic  upd_hit;
   logic  upd_fire;
   logic  wake_hit;

   assign run      = rdy && !init_valid;
   assign sel_fire = run && bus.sel_valid && bus.sel_ready;
   assign full     = &valid_q;

   always_comb begin
      upd_cur_mask = mask_q[bus.upd_entry];
      split_eff    = bus.upd_split_mask & upd_cur_mask;
      split_any    = bus.upd_split && !bus.upd_exit && (split_eff != '0);
      split_all    = split_any && (split_eff == upd_cur_mask);
      split_nt     = split_any && !split_all;
   end

   // No warp exists before the first init, so updates are refused until then.
   assign bus.upd_ready = run && started_q && !(split_nt && full);
   assign upd_hit       = valid_q[bus.upd_entry] && inflight_q[bus.upd_entry];
   assign upd_fire      = bus.upd_valid && bus.upd_ready && upd_hit;
   assign wake_hit      = run && bus.wake_valid && valid_q[bus.wake_entry];

   idx_t free_idx;
   logic free_found;

   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      for (int k = 0; k < ENTRY_NUM; k++) begin
         if (!free_found && !valid_q[k]) begin
            free_found = 1'b1;
            free_idx   = idx_t'(k);
         end
      end
   end

   logic [ENTRY_NUM-1:0] offered;
   logic [ENTRY_NUM-1:0] cand;
   logic                 merge_hit;
   logic                 merge;
   idx_t                 mi;
   idx_t                 mj;
   mask_t                merged_mask;

   // A held offer may absorb a higher entry (its mask is refreshed), but an
   // offered entry is never merged away, nor merged while being accepted.
   always_comb begin
      offered   = '0;
      cand      = '0;
      merge_hit = 1'b0;
      mi        = '0;
      mj        = '0;
      for (int k = 0; k < ENTRY_NUM; k++) begin
         offered[k] = bus.sel_valid && (bus.sel_entry == idx_t'(k));
         cand[k]    = valid_q[k] && !inflight_q[k] && !parked_q[k]
                      && !(bus.upd_valid && bus.upd_entry == idx_t'(k))
                      && !(bus.wake_valid && bus.wake_entry == idx_t'(k));
      end
      for (int i = 0; i < ENTRY_NUM - 1; i++) begin
         for (int j = i + 1; j < ENTRY_NUM; j++) begin
            if (!merge_hit && cand[i] && cand[j] && (pc_q[i] == pc_q[j])
                && !offered[j] && !(offered[i] && bus.sel_ready)) begin
               merge_hit = 1'b1;
               mi        = idx_t'(i);
               mj        = idx_t'(j);
            end
         end
      end
      merge       = merge_hit && run;
      merged_mask = mask_q[mi] | mask_q[mj];
   end

   logic [ENTRY_NUM-1:0] elig;
   idx_t                 base;
   idx_t                 idx;
   idx_t                 pick;
   logic                 found;
   mask_t                pick_mask;

   always_comb begin
      elig  = '0;
      base  = sel_fire ? bus.sel_entry : last_q;
      idx   = '0;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < ENTRY_NUM; k++) begin
         elig[k] = valid_q[k] && !inflight_q[k] && !parked_q[k] && !offered[k]
                   && !(merge && mj == idx_t'(k));
      end
      for (int k = 1; k <= ENTRY_NUM; k++) begin
         idx = base + idx_t'(k);
         if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      pick_mask = (merge && pick == mi) ? merged_mask : mask_q[pick];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q       <= '0;
         inflight_q    <= '0;
         parked_q      <= '0;
         for (int k = 0; k < ENTRY_NUM; k++) begin
            pc_q[k]   <= '0;
            mask_q[k] <= '0;
         end
         last_q        <= '1;
         started_q     <= 1'b0;
         bus.sel_valid <= 1'b0;
         bus.sel_entry <= '0;
         bus.sel_pc    <= '0;
         bus.sel_mask  <= '0;
         all_done      <= 1'b0;
         overflow      <= 1'b0;
      end else if (rdy) begin
         if (init_valid) begin
            valid_q       <= {{(ENTRY_NUM-1){1'b0}}, 1'b1};
            inflight_q    <= '0;
            parked_q      <= '0;
            pc_q[0]       <= init_pc;
            mask_q[0]     <= '1;
            last_q        <= '1;
            started_q     <= 1'b1;
            bus.sel_valid <= 1'b0;
            all_done      <= 1'b0;
            overflow      <= 1'b0;
         end else begin
            all_done <= started_q && (valid_q == '0);
            if (bus.upd_valid && started_q && split_nt && full)
               overflow <= 1'b1;

            if (sel_fire) begin
               inflight_q[bus.sel_entry] <= 1'b1;
               last_q                    <= bus.sel_entry;
            end

            if (wake_hit)
               parked_q[bus.wake_entry] <= 1'b0;

            if (merge) begin
               mask_q[mi]  <= merged_mask;
               valid_q[mj] <= 1'b0;
            end

            // Placed after the wake so a same-cycle upd_stall overrides it.
            if (upd_fire) begin
               inflight_q[bus.upd_entry] <= 1'b0;
               if (bus.upd_exit) begin
                  valid_q[bus.upd_entry]  <= 1'b0;
                  parked_q[bus.upd_entry] <= 1'b0;
               end else if (split_nt) begin
                  pc_q[bus.upd_entry]     <= bus.upd_pc;
                  mask_q[bus.upd_entry]   <= upd_cur_mask & ~split_eff;
                  parked_q[bus.upd_entry] <= bus.upd_stall;
                  valid_q[free_idx]       <= 1'b1;
                  inflight_q[free_idx]    <= 1'b0;
                  parked_q[free_idx]      <= bus.upd_stall;
                  pc_q[free_idx]          <= bus.upd_split_pc;
                  mask_q[free_idx]        <= split_eff;
               end else if (split_all) begin
                  pc_q[bus.upd_entry]     <= bus.upd_split_pc;
                  parked_q[bus.upd_entry] <= bus.upd_stall;
               end else begin
                  pc_q[bus.upd_entry]     <= bus.upd_pc;
                  parked_q[bus.upd_entry] <= bus.upd_stall;
               end
            end

            if (!bus.sel_valid || bus.sel_ready) begin
               bus.sel_valid <= found;
               bus.sel_entry <= pick;
               bus.sel_pc    <= pc_q[pick];
               bus.sel_mask  <= pick_mask;
            end else if (merge && bus.sel_entry == mi) begin
               bus.sel_mask  <= merged_mask;
            end
         end
      end
   end

endmodule

// File: tb/tb_gelato_simt_split_table.sv
// Directed bench: expected offers go into a queue and are checked by a
// monitor at every accepted handshake; status outputs are checked inline.
module tb_gelato_simt_split_table;
   localparam int TN = 32;
   localparam int EN = 8;
   localparam int PW = 32;

   typedef struct {
      int          e;
      logic [31:0] pc;
      logic [31:0] m;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rdy = 1'b0;
   logic          init_valid = 1'b0;
   logic [PW-1:0] init_pc = '0;
   logic          full;
   logic          all_done;
   logic          overflow;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   exp_t x;

   gelato_simt_split_table_if #(.THREAD_NUM(TN), .ENTRY_NUM(EN), .PC_WIDTH(PW)) bus ();

   gelato_simt_split_table #(.THREAD_NUM(TN), .ENTRY_NUM(EN), .PC_WIDTH(PW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rdy        (rdy),
      .init_valid (init_valid),
      .init_pc    (init_pc),
      .bus        (bus),
      .full       (full),
      .all_done   (all_done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && rdy && bus.sel_valid && bus.sel_ready) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL offer_unexpected: got entry %0d pc %h mask %h, required no offer",
                     bus.sel_entry, bus.sel_pc, bus.sel_mask);
         end else begin
            x = q.pop_front();
            if (int'(bus.sel_entry) != x.e || bus.sel_pc !== x.pc || bus.sel_mask !== x.m) begin
               n_bad++;
               $display("FAIL offer: got entry %0d pc %h mask %h, required entry %0d pc %h mask %h",
                        bus.sel_entry, bus.sel_pc, bus.sel_mask, x.e, x.pc, x.m);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string nm, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic push(int e, logic [31:0] pc, logic [31:0] m);
      exp_t y;
      y.e  = e;
      y.pc = pc;
      y.m  = m;
      q.push_back(y);
   endtask

   task automatic drain(string nm);
      int t = 0;
      while (q.size() != 0 && t < 30) begin
         tick();
         t++;
      end
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got %0d offers still pending after 30 cycles, required 0", nm, q.size());
         q.delete();
      end
   endtask

   task automatic quiet(int n, string nm);
      for (int i = 0; i < n; i++) begin
         tick();
         check(nm, 32'(bus.sel_valid), 32'd0);
      end
   endtask

   task automatic upd(int e, logic [31:0] pc, logic sp, logic [31:0] spc, logic [31:0] sm,
                      logic st, logic ex, logic wv, int we, int exp_ready);
      bus.upd_valid      = 1'b1;
      bus.upd_entry      = 3'(e);
      bus.upd_pc         = pc;
      bus.upd_split      = sp;
      bus.upd_split_pc   = spc;
      bus.upd_split_mask = sm;
      bus.upd_stall      = st;
      bus.upd_exit       = ex;
      bus.wake_valid     = wv;
      bus.wake_entry     = 3'(we);
      #1;
      check("upd_ready", 32'(bus.upd_ready), 32'(exp_ready));
      @(posedge clk);
      #1;
      bus.upd_valid  = 1'b0;
      bus.wake_valid = 1'b0;
   endtask

   task automatic wake(int e);
      bus.wake_valid = 1'b1;
      bus.wake_entry = 3'(e);
      tick();
      bus.wake_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.sel_ready      = 1'b0;
      bus.upd_valid      = 1'b0;
      bus.upd_entry      = '0;
      bus.upd_pc         = '0;
      bus.upd_stall      = 1'b0;
      bus.upd_split      = 1'b0;
      bus.upd_split_pc   = '0;
      bus.upd_split_mask = '0;
      bus.upd_exit       = 1'b0;
      bus.wake_valid     = 1'b0;
      bus.wake_entry     = '0;
      rdy                = 1'b1;
      repeat (2) tick();

      check("rst_sel_valid", 32'(bus.sel_valid), 32'd0);
      check("rst_sel_entry", 32'(bus.sel_entry), 32'd0);
      check("rst_sel_pc", bus.sel_pc, 32'd0);
      check("rst_sel_mask", bus.sel_mask, 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_all_done", 32'(all_done), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_upd_ready", 32'(bus.upd_ready), 32'd0);
      rst_n = 1'b1;
      tick();

      // init, offer two cycles later
      init_valid = 1'b1;
      init_pc    = 32'h100;
      tick();
      init_valid = 1'b0;
      tick();
      check("init_sel_valid", 32'(bus.sel_valid), 32'd1);
      check("init_sel_entry", 32'(bus.sel_entry), 32'd0);
      check("init_sel_pc", bus.sel_pc, 32'h100);
      check("init_sel_mask", bus.sel_mask, 32'hFFFF_FFFF);
      check("init_all_done", 32'(all_done), 32'd0);
      push(0, 32'h100, 32'hFFFF_FFFF);
      bus.sel_ready = 1'b1;
      drain("init_offer");
      quiet(3, "no_reoffer_before_update");

      // divergent split, round-robin 1 then 0
      push(1, 32'h200, 32'h0000_FFFF);
      push(0, 32'h104, 32'hFFFF_0000);
      upd(0, 32'h104, 1'b1, 32'h200, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 0, 1);
      drain("split_offers");
      check("split_full", 32'(full), 32'd0);

      // reconvergence at 0x300 while entry 0 offer is held
      bus.sel_ready = 1'b0;
      upd(0, 32'h300, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1);
      upd(1, 32'h300, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1);
      repeat (3) tick();
      check("merge_held_entry", 32'(bus.sel_entry), 32'd0);
      check("merge_held_mask", bus.sel_mask, 32'hFFFF_FFFF);
      push(0, 32'h300, 32'hFFFF_FFFF);
      bus.sel_ready = 1'b1;
      drain("merge_offer");
      quiet(3, "merged_entry_freed");
      check("merge_full", 32'(full), 32'd0);

      // fill the table: each split parks both halves, entry 0 is woken again
      for (int k = 1; k < EN; k++) begin
         push(0, 32'h400 + 32'(4 * k), ~((32'h1 << k) - 32'h1));
         upd(0, 32'h400 + 32'(4 * k), 1'b1, 32'h1000 + 32'(16 * k), 32'h1 << (k - 1),
             1'b1, 1'b0, 1'b0, 0, 1);
         wake(0);
         drain("fill_offer");
      end
      check("fill_full", 32'(full), 32'd1);

      upd(0, 32'h5FC, 1'b1, 32'h2000, 32'h100, 1'b0, 1'b0, 1'b0, 0, 0);
      check("refused_overflow", 32'(overflow), 32'd1);
      check("refused_full", 32'(full), 32'd1);
      quiet(2, "refused_stays_inflight");

      push(0, 32'h480, 32'hFFFF_FF80);
      upd(0, 32'h111, 1'b1, 32'h480, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0, 1);
      drain("whole_mask_split");
      push(0, 32'h490, 32'hFFFF_FF80);
      upd(0, 32'h490, 1'b1, 32'h999, 32'h1, 1'b0, 1'b0, 1'b0, 0, 1);
      drain("empty_split");
      check("overflow_sticky", 32'(overflow), 32'd1);

      push(7, 32'h1070, 32'h40);
      wake(7);
      drain("wake7_offer");
      upd(7, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 1);
      check("exit_frees", 32'(full), 32'd0);
      push(0, 32'h500, 32'hFFFF_FE80);
      push(7, 32'h2000, 32'h100);
      upd(0, 32'h500, 1'b1, 32'h2000, 32'h100, 1'b0, 1'b0, 1'b0, 0, 1);
      drain("retry_offers");
      check("retry_full", 32'(full), 32'd1);

      // stall and wake
      upd(0, 32'h600, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 1);
      quiet(4, "stalled_not_offered");
      upd(7, 32'h700, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 7, 1);
      quiet(4, "update_stall_beats_wake");
      push(0, 32'h600, 32'hFFFF_FE80);
      wake(0);
      drain("wake0_offer");
      push(7, 32'h700, 32'h100);
      wake(7);
      drain("wake7_again");

      // same-cycle wake + stall=0 update, offer held, then rdy freeze
      bus.sel_ready = 1'b0;
      push(0, 32'h604, 32'hFFFF_FE80);
      upd(0, 32'h604, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_sel_valid", 32'(bus.sel_valid), 32'd1);
         check("hold_sel_pc", bus.sel_pc, 32'h604);
      end
      rdy           = 1'b0;
      bus.sel_ready = 1'b1;
      bus.upd_valid = 1'b1;
      bus.upd_entry = 3'd7;
      bus.upd_exit  = 1'b1;
      bus.upd_split = 1'b0;
      #1;
      check("freeze_upd_ready", 32'(bus.upd_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("freeze_sel_valid", 32'(bus.sel_valid), 32'd1);
         check("freeze_sel_pc", bus.sel_pc, 32'h604);
      end
      bus.upd_valid = 1'b0;
      bus.upd_exit  = 1'b0;
      rdy           = 1'b1;
      drain("after_freeze");
      check("freeze_kept_entry7", 32'(full), 32'd1);

      // exit everything
      upd(0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 1);
      upd(7, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 1);
      for (int k = 1; k < EN - 1; k++) begin
         push(k, 32'h1000 + 32'(16 * k), 32'h1 << (k - 1));
         wake(k);
         drain("exit_loop_offer");
         upd(k, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 1);
      end
      repeat (2) tick();
      check("done_all_done", 32'(all_done), 32'd1);
      check("done_sel_valid", 32'(bus.sel_valid), 32'd0);
      check("done_full", 32'(full), 32'd0);
      check("done_overflow", 32'(overflow), 32'd1);

      // re-init clears sticky state, then async reset mid-cycle
      bus.sel_ready = 1'b0;
      init_valid    = 1'b1;
      init_pc       = 32'h800;
      tick();
      init_valid = 1'b0;
      check("reinit_overflow", 32'(overflow), 32'd0);
      check("reinit_all_done", 32'(all_done), 32'd0);
      tick();
      check("reinit_sel_pc", bus.sel_pc, 32'h800);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_sel_valid", 32'(bus.sel_valid), 32'd0);
      check("scoreboard_empty", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
